decoder_2to4_pipe: RTL and testbench
====================================

DECODER_2TO4_PIPE -- requirements
Module: decoder_2to4_pipe

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 8, width of the delivered-symbol counter.
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-004 The block SHALL have port in_code, input, 2 bits, binary code to decode.
REQ-005 The block SHALL have port in_en, input, 1 bit, decode enable sampled with in_code.
REQ-006 The block SHALL have port in_valid, input, 1 bit, input symbol present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, block can accept a symbol.
REQ-008 The block SHALL have port out_onehot, output, 4 bits, decoded one-hot word.
REQ-009 The block SHALL have port out_valid, output, 1 bit, out_onehot holds a valid symbol.
REQ-010 The block SHALL have port out_ready, input, 1 bit, downstream accepts the symbol.
REQ-011 The block SHALL have port cnt_clr, input, 1 bit, synchronous clear of sym_cnt.
REQ-012 The block SHALL have port sym_cnt, output, CNT_W bits, delivered-symbol count.

Function
REQ-013 Accept SHALL occur when in_valid and in_ready are both high; deliver SHALL occur when out_valid and out_ready are both high.
REQ-014 Decode rule: in_en=1 SHALL give out_onehot = 4'b0001 shifted left by in_code (00->0001, 01->0010, 10->0100, 11->1000); in_en=0 SHALL give 4'b0000.
REQ-015 Latency SHALL be 1 cycle: a symbol accepted into an empty block SHALL appear on out_valid/out_onehot the next cycle.
REQ-016 Buffering SHALL be a 2-entry skid buffer, a main register plus a skid register, with states EMPTY, ONE and FULL.
REQ-017 EMPTY: out_valid=0, in_ready=1; an accept SHALL move to ONE.
REQ-018 ONE: out_valid=1, in_ready=1; accept without deliver SHALL move to FULL, storing the new symbol in skid.
REQ-019 ONE: deliver without accept SHALL move to EMPTY.
REQ-020 ONE: simultaneous accept and deliver SHALL stay in ONE, loading the new symbol into main.
REQ-021 FULL: out_valid=1, in_ready=0; a deliver SHALL move to ONE with skid copied into main; no accept SHALL occur in FULL.
REQ-022 in_ready SHALL be a function of state only, never of out_ready, so there is no combinational in-to-out ready path.
REQ-023 While out_valid=1 and out_ready=0, out_onehot SHALL hold stable.
REQ-024 Ordering SHALL be strict FIFO; no symbol is dropped or duplicated.
REQ-025 sym_cnt SHALL increment by 1 on each deliver and saturate at 2^CNT_W-1.
REQ-026 When cnt_clr and deliver coincide, sym_cnt SHALL become 0 (clear wins).
REQ-027 Disabled symbols (0000) SHALL be buffered, delivered and counted like any other symbol.

Reset
REQ-028 While rst=1, the block SHALL hold state EMPTY, out_valid=0, out_onehot=4'b0000, sym_cnt=0, and both registers cleared.
REQ-029 While rst=1, in_ready SHALL be 0 and inputs SHALL be ignored; in_ready SHALL be 1 on the first cycle after rst falls.
REQ-030 Reset asserted mid-operation, including in FULL, SHALL discard both buffered symbols with no delivery.

Structure
REQ-031 A shared package SHALL hold the state enum (EMPTY/ONE/FULL), ONEHOT_W=4, CODE_W=2 and the default CNT_W.
REQ-032 The decode SHALL live in one combinational sub-module, decoder_2to4_core (in_code, in_en -> onehot), instantiated once at the input side.

Verification
REQ-033 Reset, then feed codes 00,01,10,11 with en=1 and out_ready=1 -> 0001,0010,0100,1000 each one cycle after accept; sym_cnt ends at 4.
REQ-034 Code 11 with en=0 -> out_onehot=0000 with out_valid=1; sym_cnt increments.
REQ-035 Backpressure: out_ready=0, offer 01 then 10 -> in_ready falls after the second accept (FULL) and out_onehot holds 0010; raise out_ready -> 0010 then 0100, in order.
REQ-036 Streaming in ONE with simultaneous accept and deliver every cycle for 10 symbols -> throughput of 1 per cycle, state never FULL, sym_cnt=10.
REQ-037 CNT_W=2: deliver 5 symbols -> sym_cnt saturates at 3; cnt_clr concurrent with a deliver -> sym_cnt=0.
REQ-038 rst pulsed while FULL -> out_valid=0 and sym_cnt=0 next cycle, no stale symbol delivered afterwards, in_ready=1 one cycle after rst falls.

Source files
------------

// File: rtl/decoder_2to4_pipe_pkg.sv
// Shared definitions for the 2-to-4 decoder pipeline.
//   ONEHOT_W      : width of the decoded one-hot word
//   CODE_W        : width of the binary input code
//   CNT_W_DEFAULT : default width of the delivered-symbol counter
//   state_t       : skid-buffer occupancy (EMPTY / ONE / FULL)
package decoder_2to4_pipe_pkg;
  localparam int ONEHOT_W      = 4;
  localparam int CODE_W        = 2;
  localparam int CNT_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;
endpackage

// File: rtl/decoder_2to4_core.sv
// Combinational 2-to-4 decoder.
//   in_code : binary code to decode
//   in_en   : enable; when low the output word is all zeros
//   onehot  : decoded word, bit in_code set when enabled
module decoder_2to4_core
  import decoder_2to4_pipe_pkg::*;
(
  input  logic [CODE_W-1:0]   in_code,
  input  logic                in_en,
  output logic [ONEHOT_W-1:0] onehot
);

  generate
    for (genvar gi = 0; gi < ONEHOT_W; gi++) begin : g_bit
      assign onehot[gi] = in_en && (in_code == CODE_W'(gi));
    end
  endgenerate

endmodule

// File: rtl/decoder_2to4_pipe.sv
// Pipelined 2-to-4 decoder with a 2-entry skid buffer and a saturating
// delivered-symbol counter.
//   clk, rst      : clock and synchronous active-high reset
//   in_code/in_en : symbol to decode, qualified by in_valid
//   in_valid      : upstream offers a symbol
//   in_ready      : block can take a symbol (depends on state and reset only)
//   out_onehot    : decoded word at the head of the buffer
//   out_valid     : out_onehot holds a symbol
//   out_ready     : downstream takes the symbol
//   cnt_clr       : synchronous clear of sym_cnt (wins over an increment)
//   sym_cnt       : number of delivered symbols, saturating
module decoder_2to4_pipe
  import decoder_2to4_pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                in_en,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ONEHOT_W-1:0] out_onehot,
  output logic                out_valid,
  input  logic                out_ready,
  input  logic                cnt_clr,
  output logic [CNT_W-1:0]    sym_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t              state_reg, state_next;
  logic [ONEHOT_W-1:0] main_reg, main_next;
  logic [ONEHOT_W-1:0] skid_reg, skid_next;
  logic [CNT_W-1:0]    cnt_reg, cnt_next;
  logic [ONEHOT_W-1:0] dec_word;
  logic                accept;
  logic                deliver;

  // Decode happens before buffering so both registers hold final words.
  decoder_2to4_core u_core (
    .in_code (in_code),
    .in_en   (in_en),
    .onehot  (dec_word)
  );

  assign accept     = in_valid && in_ready;
  assign deliver    = out_valid && out_ready;
  assign out_onehot = main_reg;
  assign sym_cnt    = cnt_reg;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= EMPTY;
      main_reg  <= '0;
      skid_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      main_reg  <= main_next;
      skid_reg  <= skid_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state and buffer steering.
  always_comb begin
    state_next = state_reg;
    main_next  = main_reg;
    skid_next  = skid_reg;
    case (state_reg)
      EMPTY: begin
        if (accept) begin
          state_next = ONE;
          main_next  = dec_word;
        end
      end
      ONE: begin
        if (accept && !deliver) begin
          // Head is stalled: park the newcomer behind it.
          state_next = FULL;
          skid_next  = dec_word;
        end else if (accept && deliver) begin
          main_next = dec_word;
        end else if (deliver) begin
          state_next = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          state_next = ONE;
          main_next  = skid_reg;
        end
      end
      default: state_next = EMPTY;
    endcase
  end

  // Counter: clear has priority, increment saturates at all-ones.
  always_comb begin
    cnt_next = cnt_reg;
    if (cnt_clr) begin
      cnt_next = '0;
    end else if (deliver && (cnt_reg != CNT_MAX)) begin
      cnt_next = cnt_reg + 1'b1;
    end
  end

  // Handshake outputs. Both are forced low during reset so nothing is
  // accepted or delivered while the buffer is being discarded; in_ready
  // never looks at out_ready.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (!rst) begin
      case (state_reg)
        EMPTY: in_ready = 1'b1;
        ONE: begin
          in_ready  = 1'b1;
          out_valid = 1'b1;
        end
        FULL: out_valid = 1'b1;
        default: begin
          in_ready  = 1'b0;
          out_valid = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decoder_2to4_pipe.sv
module tb_decoder_2to4_pipe;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] in_code;
  logic       in_en;
  logic       in_valid;
  logic       in_ready, in_ready2;
  logic [3:0] out_onehot, out_onehot2;
  logic       out_valid, out_valid2;
  logic       out_ready;
  logic       cnt_clr;
  logic [7:0] sym_cnt;
  logic [1:0] sym_cnt2;

  int n_cmp = 0;
  int n_err = 0;
  int exp_cnt = 0;
  int exp_cnt2 = 0;
  logic [3:0] sb[$];

  always #5 clk = ~clk;

  decoder_2to4_pipe #(.CNT_W(8)) dut (
    .clk(clk), .rst(rst), .in_code(in_code), .in_en(in_en),
    .in_valid(in_valid), .in_ready(in_ready), .out_onehot(out_onehot),
    .out_valid(out_valid), .out_ready(out_ready), .cnt_clr(cnt_clr),
    .sym_cnt(sym_cnt)
  );

  // Narrow-counter instance driven with the same stimulus.
  decoder_2to4_pipe #(.CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .in_code(in_code), .in_en(in_en),
    .in_valid(in_valid), .in_ready(in_ready2), .out_onehot(out_onehot2),
    .out_valid(out_valid2), .out_ready(out_ready), .cnt_clr(cnt_clr),
    .sym_cnt(sym_cnt2)
  );

  function automatic logic [3:0] model_dec(input logic [1:0] c, input logic e);
    logic [3:0] r;
    r = 4'b0001 << c;
    return e ? r : 4'b0000;
  endfunction

  // One clock: observe handshakes mid-cycle, update scoreboard and counter
  // models, then return 1 time unit after the rising edge.
  task automatic tick(output bit dlv, output logic [3:0] val);
    @(negedge clk);
    dlv = 1'b0;
    val = out_onehot;
    if (rst) begin
      sb.delete();
      exp_cnt  = 0;
      exp_cnt2 = 0;
    end else begin
      dlv = out_valid && out_ready;
      if (in_valid && in_ready) sb.push_back(model_dec(in_code, in_en));
      if (cnt_clr) begin
        exp_cnt  = 0;
        exp_cnt2 = 0;
      end else if (dlv) begin
        if (exp_cnt < 255) exp_cnt++;
        if (exp_cnt2 < 3) exp_cnt2++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    bit d;
    logic [3:0] v;
    rst = 1'b1; in_valid = 1'b1; in_code = 2'd2; in_en = 1'b1;
    out_ready = 1'b1; cnt_clr = 1'b0;
    tick(d, v);
    tick(d, v);
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %b expected 0", in_ready); end
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (out_onehot !== 4'b0000) begin n_err++; $display("FAIL rst_onehot: got %b expected 0000", out_onehot); end
    n_cmp++;
    if (sym_cnt !== 8'd0) begin n_err++; $display("FAIL rst_cnt: got %0d expected 0", sym_cnt); end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_ready: got %b expected 1", in_ready); end
    $display("reset checked");
  endtask

  task automatic test_decode_all;
    bit d;
    logic [3:0] v, e;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_code = 2'(i); in_en = 1'b1; in_valid = 1'b1;
      tick(d, v);
      in_valid = 1'b0;
      n_cmp++;
      if (out_valid !== 1'b1 || out_onehot !== model_dec(2'(i), 1'b1)) begin
        n_err++;
        $display("FAIL decode_latency: got valid=%b onehot=%b expected valid=1 onehot=%b",
                 out_valid, out_onehot, model_dec(2'(i), 1'b1));
      end
      tick(d, v);
      n_cmp++;
      if (!d || sb.size() == 0) begin
        n_err++; $display("FAIL decode_deliver: got deliver=%b expected deliver=1", d);
      end else begin
        e = sb.pop_front();
        if (v !== e) begin n_err++; $display("FAIL decode_data: got %b expected %b", v, e); end
        else $display("code %0d delivered %b", i, v);
      end
    end
    n_cmp++;
    if (sym_cnt !== 8'd4) begin n_err++; $display("FAIL decode_cnt: got %0d expected 4", sym_cnt); end
  endtask

  task automatic test_disabled;
    bit d;
    logic [3:0] v, e;
    out_ready = 1'b1;
    in_code = 2'd3; in_en = 1'b0; in_valid = 1'b1;
    tick(d, v);
    in_valid = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_onehot !== 4'b0000) begin
      n_err++; $display("FAIL disabled_out: got valid=%b onehot=%b expected valid=1 onehot=0000", out_valid, out_onehot);
    end
    tick(d, v);
    n_cmp++;
    if (!d || sb.size() == 0) begin
      n_err++; $display("FAIL disabled_deliver: got deliver=%b expected deliver=1", d);
    end else begin
      e = sb.pop_front();
      if (v !== e) begin n_err++; $display("FAIL disabled_data: got %b expected %b", v, e); end
      else $display("disabled symbol delivered %b", v);
    end
    n_cmp++;
    if (sym_cnt !== 8'd5) begin n_err++; $display("FAIL disabled_cnt: got %0d expected 5", sym_cnt); end
  endtask

  task automatic test_backpressure;
    bit d;
    logic [3:0] v, e;
    out_ready = 1'b0; in_en = 1'b1; in_valid = 1'b1;
    in_code = 2'd1;
    tick(d, v);
    in_code = 2'd2;
    tick(d, v);
    in_code = 2'd3;  // offered while FULL: must not be taken
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_onehot !== 4'b0010) begin
        n_err++;
        $display("FAIL bp_hold: got ready=%b valid=%b onehot=%b expected ready=0 valid=1 onehot=0010",
                 in_ready, out_valid, out_onehot);
      end
      tick(d, v);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(d, v);
      n_cmp++;
      if (!d || sb.size() == 0) begin
        n_err++; $display("FAIL bp_deliver: got deliver=%b expected deliver=1", d);
      end else begin
        e = sb.pop_front();
        if (v !== e) begin n_err++; $display("FAIL bp_order: got %b expected %b", v, e); end
        else $display("backpressure delivered %b", v);
      end
    end
    n_cmp++;
    if (out_valid !== 1'b0 || sb.size() != 0) begin
      n_err++; $display("FAIL bp_drain: got valid=%b pending=%0d expected valid=0 pending=0", out_valid, sb.size());
    end
  endtask

  task automatic test_back_to_back;
    bit d;
    logic [3:0] v, e;
    int got;
    out_ready = 1'b1; in_valid = 1'b0; cnt_clr = 1'b1;
    tick(d, v);
    cnt_clr = 1'b0;
    got = 0;
    for (int i = 0; i <= 10; i++) begin
      in_valid = (i < 10); in_code = 2'(i % 4); in_en = (i % 3 != 2);
      if (i > 0) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %b expected 1 at step %0d", in_ready, i); end
      end
      tick(d, v);
      if (i > 0) begin
        n_cmp++;
        if (!d || sb.size() == 0) begin
          n_err++; $display("FAIL b2b_deliver: got deliver=%b expected deliver=1 at step %0d", d, i);
        end else begin
          e = sb.pop_front();
          got++;
          if (v !== e) begin n_err++; $display("FAIL b2b_data: got %b expected %b", v, e); end
          else $display("stream symbol %0d delivered %b", got, v);
        end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (sym_cnt !== 8'd10 || int'(sym_cnt) != exp_cnt) begin
      n_err++; $display("FAIL b2b_cnt: got %0d expected 10", sym_cnt);
    end
  endtask

  task automatic test_saturate;
    bit d;
    logic [3:0] v, e;
    out_ready = 1'b1; in_valid = 1'b0; cnt_clr = 1'b1;
    tick(d, v);
    cnt_clr = 1'b0;
    for (int i = 0; i < 6; i++) begin
      in_valid = (i < 5); in_code = 2'(i % 4); in_en = 1'b1;
      tick(d, v);
      if (d && sb.size() != 0) begin
        e = sb.pop_front();
        n_cmp++;
        if (v !== e) begin n_err++; $display("FAIL sat_data: got %b expected %b", v, e); end
      end
    end
    in_valid = 1'b0;
    n_cmp++;
    if (sym_cnt2 !== 2'd3 || int'(sym_cnt2) != exp_cnt2) begin
      n_err++; $display("FAIL sat_cnt: got %0d expected 3", sym_cnt2);
    end else $display("narrow counter saturated at %0d", sym_cnt2);
    in_valid = 1'b1; in_code = 2'd0;
    tick(d, v);
    in_valid = 1'b0; cnt_clr = 1'b1;
    tick(d, v);
    cnt_clr = 1'b0;
    if (d && sb.size() != 0) e = sb.pop_front();
    n_cmp++;
    if (!d) begin n_err++; $display("FAIL clr_deliver: got deliver=0 expected deliver=1"); end
    n_cmp++;
    if (sym_cnt2 !== 2'd0 || sym_cnt !== 8'd0) begin
      n_err++; $display("FAIL clr_wins: got %0d/%0d expected 0/0", sym_cnt2, sym_cnt);
    end else $display("clear won over deliver");
  endtask

  task automatic test_reset_full;
    bit d;
    logic [3:0] v;
    out_ready = 1'b0; in_en = 1'b1; in_valid = 1'b1;
    in_code = 2'd3;
    tick(d, v);
    in_code = 2'd1;
    tick(d, v);
    in_valid = 1'b0;
    n_cmp++;
    if (in_ready !== 1'b0) begin n_err++; $display("FAIL rf_full: got ready=%b expected 0", in_ready); end
    rst = 1'b1;
    tick(d, v);
    n_cmp++;
    if (out_valid !== 1'b0 || sym_cnt !== 8'd0 || out_onehot !== 4'b0000) begin
      n_err++; $display("FAIL rf_cleared: got valid=%b cnt=%0d onehot=%b expected 0/0/0000", out_valid, sym_cnt, out_onehot);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin n_err++; $display("FAIL rf_ready: got %b expected 1", in_ready); end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(d, v);
      n_cmp++;
      if (d) begin n_err++; $display("FAIL rf_stale: got delivery %b expected none", v); end
    end
    $display("reset while full discarded buffered symbols");
  endtask

  initial begin
    rst = 1'b1; in_code = '0; in_en = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; cnt_clr = 1'b0;
    test_reset();
    test_decode_all();
    test_disabled();
    test_backpressure();
    test_back_to_back();
    test_saturate();
    test_reset_full();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
